// File: rtl/multi_toggle_rx.sv
// Multi-channel toggle receiver: synchronizes per-channel source toggles into clk
// and presents them as one-cycle pulses (HOLD=0) or held, acknowledged events (HOLD=1).
module multi_toggle_rx #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD        = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] src_tgl,
  input  logic [NCH-1:0] evt_ack,
  input  logic [NCH-1:0] ovf_clr,
  output logic [NCH-1:0] evt,
  output logic [NCH-1:0] ack_tgl,
  output logic [NCH-1:0] ovf
);

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("multi_toggle_rx: NCH=%0d outside 1..32", NCH);
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("multi_toggle_rx: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end
  if (HOLD < 0 || HOLD > 1) begin : g_bad_hold
    $error("multi_toggle_rx: HOLD=%0d must be 0 or 1", HOLD);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_q;
    logic                   s;
    logic                   e;

    // Plain shift chain: nothing may sit between synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        d_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], src_tgl[i]};
        d_q    <= sync_q[SYNC_STAGES-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
    assign e = s ^ d_q;

    if (HOLD == 0) begin : g_pulse
      logic unused_in;
      assign unused_in  = evt_ack[i] ^ ovf_clr[i];
      assign evt[i]     = e;
      assign ack_tgl[i] = d_q;
      assign ovf[i]     = 1'b0;
    end else begin : g_hold
      logic pend_q;
      logic ack_q;
      logic ovf_q;
      logic consume;

      assign consume = pend_q & evt_ack[i];

      // A new edge always (re)arms pend; it only overflows when the old event was not taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_q <= 1'b0;
          ack_q  <= 1'b0;
          ovf_q  <= 1'b0;
        end else begin
          if (e) begin
            pend_q <= 1'b1;
          end else if (consume) begin
            pend_q <= 1'b0;
          end
          if (consume) begin
            ack_q <= ~ack_q;
          end
          if (e && pend_q && !evt_ack[i]) begin
            ovf_q <= 1'b1;
          end else if (ovf_clr[i]) begin
            ovf_q <= 1'b0;
          end
        end
      end

      assign evt[i]     = pend_q;
      assign ack_tgl[i] = ack_q;
      assign ovf[i]     = ovf_q;
    end
  end

endmodule

// File: doc/multi_toggle_rx.md
MULTI_TOGGLE_RX -- requirements
Module: multi_toggle_rx

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n; no other clock or reset ports.
REQ-002 Parameter NCH SHALL default to 4 and give the number of independent channels; legal range is 1..32.
REQ-003 Parameter SYNC_STAGES SHALL default to 2 and give the synchronizer depth per channel; legal range is 2..4.
REQ-004 Parameter HOLD SHALL default to 1: 1 selects held-event mode, 0 selects pulse mode.
REQ-005 Port clk SHALL be an input, 1 bit: destination clock.
REQ-006 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-007 Port src_tgl SHALL be an input, NCH bits: per-channel toggle lines from a foreign domain, asynchronous to clk.
REQ-008 Port evt_ack SHALL be an input, NCH bits: per-channel consumer acknowledge; used only when HOLD=1.
REQ-009 Port ovf_clr SHALL be an input, NCH bits: per-channel clear of the sticky overflow flag.
REQ-010 Port evt SHALL be an output, NCH bits: per-channel event, either a one-cycle pulse (HOLD=0) or a held pending level (HOLD=1).
REQ-011 Port ack_tgl SHALL be an output, NCH bits: per-channel return toggle to the source domain, flipping once per consumed event.
REQ-012 Port ovf SHALL be an output, NCH bits: per-channel sticky overflow flag.

Function
REQ-013 Each src_tgl bit SHALL pass through its own chain of SYNC_STAGES flops clocked by clk; the last stage is s[i]. No logic is allowed between stages, and no bit feeds more than one chain.
REQ-014 A delay flop SHALL hold d[i] <= s[i] every cycle; the edge term is e[i] = s[i] XOR d[i].
REQ-015 Latency: when src_tgl[i] changes and meets setup before clk edge k, e[i] SHALL be high for exactly the one cycle following edge k+SYNC_STAGES-1.
REQ-016 If HOLD=0: evt[i] SHALL equal e[i], a one-cycle pulse per toggle; ack_tgl[i] SHALL equal d[i]; ovf SHALL stay 0; evt_ack SHALL be ignored.
REQ-017 If HOLD=1: a flop pend[i] SHALL drive evt[i]; pend[i] is set at any edge where e[i]=1.
REQ-018 If HOLD=1: pend[i] SHALL clear at an edge where pend[i]=1, evt_ack[i]=1 and e[i]=0.
REQ-019 If HOLD=1: at an edge where pend[i]=1, evt_ack[i]=1 and e[i]=1, pend[i] SHALL stay 1 (new event replaces the consumed one) and ovf SHALL NOT be set.
REQ-020 If HOLD=1: at an edge where pend[i]=1, evt_ack[i]=0 and e[i]=1, pend[i] SHALL stay 1, ovf[i] SHALL be set, and the new event is merged (lost).
REQ-021 If HOLD=1: evt_ack[i] SHALL be ignored while pend[i]=0.
REQ-022 If HOLD=1: ack_tgl[i] SHALL be a flop that inverts at every edge where pend[i]=1 and evt_ack[i]=1, and at no other edge.
REQ-023 ovf[i] SHALL clear at an edge where ovf_clr[i]=1; if set and clear occur at the same edge, set SHALL win.
REQ-024 Channels SHALL be fully independent; activity on one channel SHALL NOT change the state of any other channel.
REQ-025 All outputs SHALL be driven from flops, or from e[] in HOLD=0 mode; there SHALL be no combinational path from any input to any output.
REQ-026 Out-of-range NCH, SYNC_STAGES or HOLD values SHALL cause an elaboration-time error.

Reset
REQ-027 While rst_n=0, all synchronizer stages, d, pend, ack_tgl and ovf SHALL be 0 immediately (asynchronous), so evt=0, ack_tgl=0 and ovf=0.
REQ-028 Reset deassertion SHALL take effect at the next clk edge.
REQ-029 A src_tgl level of 1 present at reset release SHALL be seen as one toggle and produce one event SYNC_STAGES cycles later.
REQ-030 Reset mid-operation SHALL discard all pending events and overflow flags and SHALL NOT produce a spurious evt on the cycle after release, other than the event required by REQ-029.

Verification
REQ-031 HOLD=0, SYNC_STAGES=2: src_tgl[0] goes 0->1 before edge 5 -> evt[0]=1 only in the cycle after edge 6, and ack_tgl[0]=1 from edge 7 onward.
REQ-032 HOLD=1, NCH=4: toggle ch2, hold evt_ack=0 for 10 cycles, then pulse evt_ack[2]=1 for one cycle -> evt[2] held high for those 10+ cycles, drops after the ack edge, ack_tgl[2] flips once, other channels unaffected.
REQ-033 HOLD=1: toggle ch1 twice, 6 cycles apart, with no ack -> evt[1] stays 1, ovf[1]=1 after the second event; ovf_clr[1] pulse -> ovf[1]=0.
REQ-034 HOLD=1: second event's e[1] coincides with evt_ack[1]=1 -> pend stays 1, ovf[1]=0, ack_tgl[1] flips once; a further ack clears pend.
REQ-035 Assert rst_n=0 mid-pending with ovf set, src_tgl=4'b0101 -> evt, ack_tgl and ovf go 0 immediately; after release, events on ch0 and ch2 only.
REQ-036 SYNC_STAGES=3 and 4, with random toggle spacing of at least 2*SYNC_STAGES+2 cycles -> count of evt (plus ovf) matches the count of src toggles per channel.
